// File: rtl/mem_burst_initiator.sv
// Burst initiator for a single-port byte memory: one command becomes a run of
// single-beat accesses, with write data and read data carried on valid/ready streams.
module mem_burst_initiator #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              last_beat;
  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_load;
  logic              rd_pop;

  assign last_beat = (remaining == '0);
  // The memory always sees the current burst address; mem_we alone qualifies an access.
  assign mem_addr  = cur_addr;

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    busy       = 1'b1;
    done       = 1'b0;
    cmd_fire   = 1'b0;
    wr_fire    = 1'b0;
    rd_load    = 1'b0;
    rd_pop     = 1'b0;
    case (state)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_fire   = 1'b1;
          state_next = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_wdata = wr_data;
        if (wr_valid) begin
          wr_fire = 1'b1;
          if (last_beat) state_next = S_DONE;
        end
      end
      S_READ: begin
        // Refill the output register whenever it is empty or being drained this cycle.
        rd_load = !rd_valid || rd_ready;
        if (rd_load && last_beat) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        rd_pop = rd_valid && rd_ready;
        if (rd_pop) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (cmd_fire) begin
      cur_addr  <= cmd_addr;
      remaining <= cmd_len;
    end else if (wr_fire || rd_load) begin
      // Address wraps naturally at 2**ADDR_W; remaining wraps after the last beat, unused then.
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else if (rd_load) begin
      rd_valid <= 1'b1;
      rd_last  <= last_beat;
      rd_data  <= mem_rdata;
    end else if (rd_pop) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Self-checking bench for mem_burst_initiator: a cycle table for the basic write burst,
// then scoreboarded read/write bursts covering wrap, backpressure, write gaps and reset.
module tb_mem_burst_initiator;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       done;
  logic [1:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_burst_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory instance the initiator drives: combinational read, write on the clock edge.
  logic [7:0] mem [4];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rd_exp_t;

  typedef struct {
    logic       cmd_valid, cmd_write;
    logic [1:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       e_cmd_ready, e_wr_ready, e_mem_we;
    logic [1:0] e_mem_addr;
    logic [7:0] e_mem_wdata;
    logic       e_busy, e_done;
  } vec_t;

  wr_exp_t    wr_q [$];
  rd_exp_t    rd_q [$];
  logic [7:0] ref_mem [4];
  logic [7:0] wbuf [16];
  vec_t       vecs [7];
  int         n_pass = 0;
  int         n_total = 0;
  bit         sb_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: memory writes and read-stream handshakes, plus hold-while-stalled.
  initial begin
    wr_exp_t    we;
    rd_exp_t    re;
    logic       held_v;
    logic [7:0] held_data;
    logic       held_last;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sb_en) begin
        if (mem_we) begin
          if (wr_q.size() == 0) check("wr_unexpected", mem_we, 1'b0);
          else begin
            we = wr_q.pop_front();
            check("wr_addr", mem_addr, we.addr);
            check("wr_data", mem_wdata, we.data);
          end
        end
        if (held_v) begin
          check("rd_hold_valid", rd_valid, 1'b1);
          check("rd_hold_data", rd_data, held_data);
          check("rd_hold_last", rd_last, held_last);
        end
        if (rd_valid && rd_ready) begin
          if (rd_q.size() == 0) check("rd_unexpected", rd_valid, 1'b0);
          else begin
            re = rd_q.pop_front();
            check("rd_data", rd_data, re.data);
            check("rd_last", rd_last, re.last);
          end
        end
        held_v    = rd_valid && !rd_ready;
        held_data = rd_data;
        held_last = rd_last;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic start_cmd(input logic w, input logic [1:0] addr, input logic [3:0] len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input logic [1:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_q.push_back('{addr: a, data: d});
    ref_mem[a] = d;
    @(negedge clk);
    check("wr_ready", wr_ready, 1'b1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [1:0] addr, input int len, input int gap);
    logic [1:0] a;
    a = addr;
    start_cmd(1'b1, addr, 4'(len));
    for (int i = 0; i <= len; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          wr_data = 8'hFF;
          @(negedge clk);
          check("gap_no_we", mem_we, 1'b0);
          tick();
        end
      end
      write_beat(a, wbuf[i]);
      a++;
    end
    @(negedge clk);
    check("wr_done", done, 1'b1);
    tick();
  endtask

  // mode 0: rd_ready held high, with latency/back-to-back checks; mode 1: rd_ready 1,0,0 repeating.
  task automatic read_burst(input logic [1:0] addr, input int len, input int mode);
    logic [1:0] a;
    bit         seen;
    int         cyc;
    a    = addr;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i <= len; i++) begin
      rd_q.push_back('{data: ref_mem[a], last: (i == len)});
      a++;
    end
    start_cmd(1'b0, addr, 4'(len));
    while (!seen && cyc < 200) begin
      rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      @(negedge clk);
      if (mode == 0 && cyc == 0) check("rd_latency", rd_valid, 1'b0);
      if (mode == 0 && cyc >= 1 && cyc <= len + 1) check("rd_back_to_back", rd_valid, 1'b1);
      if (done) begin
        seen = 1;
        check("rd_done_after_drain", rd_q.size(), 0);
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_done_seen", seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_mem_addr", mem_addr, 2'd0);
    tick();
    rst_n = 1'b1;

    // Write burst addr 0 len 3 as a per-cycle table; also covers a command ignored while
    // busy, write data ignored in DONE, and the one-cycle done pulse after the 4th beat.
    vecs[0] = '{1, 1, 2'd0, 4'd3, 0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 0, 0};
    vecs[1] = '{0, 0, 2'd0, 4'd0, 1, 8'h11, 0, 1, 1, 2'd0, 8'h11, 1, 0};
    vecs[2] = '{1, 1, 2'd2, 4'd0, 1, 8'h22, 0, 1, 1, 2'd1, 8'h22, 1, 0};
    vecs[3] = '{0, 0, 2'd0, 4'd0, 1, 8'h33, 0, 1, 1, 2'd2, 8'h33, 1, 0};
    vecs[4] = '{0, 0, 2'd0, 4'd0, 1, 8'h44, 0, 1, 1, 2'd3, 8'h44, 1, 0};
    vecs[5] = '{0, 0, 2'd0, 4'd0, 1, 8'h55, 0, 0, 0, 2'd0, 8'h00, 1, 1};
    vecs[6] = '{0, 0, 2'd0, 4'd0, 0, 8'h00, 1, 0, 0, 2'd0, 8'h00, 0, 0};
    for (int i = 0; i < 7; i++) begin
      cmd_valid = vecs[i].cmd_valid;
      cmd_write = vecs[i].cmd_write;
      cmd_addr  = vecs[i].cmd_addr;
      cmd_len   = vecs[i].cmd_len;
      wr_valid  = vecs[i].wr_valid;
      wr_data   = vecs[i].wr_data;
      @(negedge clk);
      check($sformatf("t%0d_cmd_ready", i), cmd_ready, vecs[i].e_cmd_ready);
      check($sformatf("t%0d_wr_ready", i), wr_ready, vecs[i].e_wr_ready);
      check($sformatf("t%0d_mem_we", i), mem_we, vecs[i].e_mem_we);
      check($sformatf("t%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      check($sformatf("t%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      check($sformatf("t%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("t%0d_done", i), done, vecs[i].e_done);
      tick();
    end
    cmd_valid  = 1'b0;
    wr_valid   = 1'b0;
    ref_mem[0] = 8'h11;
    ref_mem[1] = 8'h22;
    ref_mem[2] = 8'h33;
    ref_mem[3] = 8'h44;
    sb_en      = 1;

    // Read back 11,22,33,44 with rd_ready held high
    read_burst(2'd0, 3, 0);

    // Wrap: write AA@3, BB@0, then 6-beat read from addr 2
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    write_burst(2'd3, 1, 0);
    read_burst(2'd2, 5, 0);

    // Backpressure on a 4-beat read
    read_burst(2'd1, 3, 1);

    // Write with 2-cycle gaps between beats, then read it back under backpressure
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'h6B;
    wbuf[2] = 8'h7C;
    write_burst(2'd1, 2, 2);
    read_burst(2'd0, 3, 1);

    // Reset in the middle of a write burst while cur_addr=2
    start_cmd(1'b1, 2'd0, 4'd3);
    write_beat(2'd0, 8'h91);
    write_beat(2'd1, 8'h92);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_mem_addr", mem_addr, 2'd0);
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    read_burst(2'd2, 0, 0);

    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
